// File: rtl/os_skew_feeder_pkg.sv
// Shared types for the output-stationary skew feeder.
// State encoding and drain-length helper.
package os_skew_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/os_skew_delay_line.sv
// DEPTH x DW shift register with synchronous active-low reset.
// One instance per skewed lane.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/os_skew_feeder.sv
// Skewing feeder and sequencer for the output-stationary PE array.
// Optional perf counters under OS_SKEW_FEEDER_PERF_EN.
module os_skew_feeder
  import os_skew_feeder_pkg::*;
#(
  parameter int ROW_len = 3,
  parameter int COL_len = 3,
  parameter int DW      = 8,
  parameter int K_MAX   = 256,
  parameter int KW      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROW_len*DW-1:0] in_a_vec,
  input  logic [COL_len*DW-1:0] in_b_vec,
  output logic [ROW_len*DW-1:0] a_bus,
  output logic [COL_len*DW-1:0] b_bus,
  output logic                  compute_en,
  output logic                  read_en,
  output logic                  row_valid,
  output logic [7:0]            row_idx,
  output logic                  busy,
`ifdef OS_SKEW_FEEDER_PERF_EN
  output logic [31:0]           cnt_busy,
  output logic [31:0]           cnt_bubble,
`endif
  output logic                  done
);

  localparam int DRAIN_N = drain_len(ROW_len, COL_len);

  state_t        state_q, state_d;
  logic [KW-1:0] klen_q, kcnt_q;
  logic [7:0]    cnt_q;
  logic          done_q, rv_q;
  logic [7:0]    idx_q;
  logic          fire, acc_start;
  logic          feed_last, drain_last, read_last;

  assign fire       = in_valid && in_ready;
  assign acc_start  = (state_q == ST_IDLE) && start;
  assign feed_last  = fire && (kcnt_q == klen_q - KW'(1));
  assign drain_last = (cnt_q == 8'(DRAIN_N - 1));
  assign read_last  = (cnt_q == 8'(ROW_len - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && k_len != '0) state_d = ST_FEED;
      ST_FEED:  if (feed_last)  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_READ;
      ST_READ:  if (read_last)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_FEED);
    compute_en = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    read_en    = (state_q == ST_READ);
    busy       = (state_q != ST_IDLE);
  end

  // cnt_q times both the drain window and the readout window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      klen_q <= '0;
      kcnt_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      idx_q  <= '0;
    end else begin
      done_q <= (acc_start && k_len == '0)
             || (state_q == ST_READ && read_last);
      if (acc_start) begin
        klen_q <= k_len;
        kcnt_q <= '0;
      end else if (fire) begin
        kcnt_q <= kcnt_q + KW'(1);
      end
      if (state_d != state_q) cnt_q <= '0;
      else if (state_q == ST_DRAIN || state_q == ST_READ)
        cnt_q <= cnt_q + 8'd1;
      rv_q  <= read_en;
      idx_q <= read_en ? 8'(ROW_len - 1) - cnt_q : 8'd0;
    end
  end

  assign done      = done_q;
  assign row_valid = rv_q;
  assign row_idx   = idx_q;

  for (genvar i = 0; i < ROW_len; i++) begin : g_a
    logic [DW-1:0] lane_in;
    assign lane_in = fire ? in_a_vec[(i+1)*DW-1 -: DW] : '0;
    skew_delay_line #(.DEPTH(i + 1), .DW(DW)) u_dl (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   (lane_in),
      .q_o   (a_bus[(i+1)*DW-1 -: DW])
    );
  end

  for (genvar j = 0; j < COL_len; j++) begin : g_b
    logic [DW-1:0] lane_in;
    assign lane_in = fire ? in_b_vec[(j+1)*DW-1 -: DW] : '0;
    skew_delay_line #(.DEPTH(j + 1), .DW(DW)) u_dl (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   (lane_in),
      .q_o   (b_bus[(j+1)*DW-1 -: DW])
    );
  end

`ifdef OS_SKEW_FEEDER_PERF_EN
  logic [31:0] cbusy_q, cbub_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cbusy_q <= '0;
      cbub_q  <= '0;
    end else if (acc_start) begin
      cbusy_q <= '0;
      cbub_q  <= '0;
    end else begin
      if (busy && cbusy_q != '1) cbusy_q <= cbusy_q + 32'd1;
      if (state_q == ST_FEED && !in_valid && cbub_q != '1)
        cbub_q <= cbub_q + 32'd1;
    end
  end

  assign cnt_busy   = cbusy_q;
  assign cnt_bubble = cbub_q;
`endif

endmodule
